// File: rtl/mine_placer.sv
// Mine layout generator: clears all board arrays, then places the level's mine count via a free-running LFSR.
// Optional build macro MINE_PLACER_SAFE_NEIGHBOURS_EN widens the keep-out area to the 3x3 block around the safe cell.
module mine_placer #(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          MINES_EASY   = 10,
    parameter int          MINES_MEDIUM = 15,
    parameter int          MINES_HARD   = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         level,
    input  logic [4:0]         safe_x,
    input  logic [4:0]         safe_y,
    output logic [7:0][7:0]    array_easy_out,
    output logic [9:0][9:0]    array_medium_out,
    output logic [15:0][15:0]  array_hard_out,
    output logic               busy,
    output logic               done,
    output logic [5:0]         mines_placed
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_PLACE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] TGT_EASY   = 6'(MINES_EASY);
    localparam logic [5:0] TGT_MEDIUM = 6'(MINES_MEDIUM);
    localparam logic [5:0] TGT_HARD   = 6'(MINES_HARD);

    state_t             state_r, state_nxt_s;
    logic               busy_r, done_r, busy_nxt_s, done_nxt_s;
    logic [15:0]        lfsr_r;
    logic [1:0]         level_r;
    logic [4:0]         safe_cx_r, safe_cy_r;
    logic               safe_valid_r;
    logic [5:0]         target_r;
    logic [5:0]         placed_r;
    logic [5:0]         placed_inc_s;
    logic [7:0][7:0]    array_easy_r;
    logic [9:0][9:0]    array_medium_r;
    logic [15:0][15:0]  array_hard_r;
    logic [3:0]         cand_x_s, cand_y_s;
    logic               in_range_s, occupied_s, excluded_s, accept_s;
    logic [5:0]         cx6_s, cy6_s, sx6_s, sy6_s;
    logic               start_ok_s;

    assign start_ok_s   = start && (level != 2'd0);
    assign placed_inc_s = placed_r + 6'd1;

    // LFSR: Fibonacci taps 16,14,13,11, free-running in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    // Candidate coordinate extraction, range check and occupancy lookup for the latched level.
    always_comb begin
        cand_x_s   = 4'd0;
        cand_y_s   = 4'd0;
        in_range_s = 1'b0;
        occupied_s = 1'b0;
        case (level_r)
            2'd1: begin
                cand_x_s   = {1'b0, lfsr_r[2:0]};
                cand_y_s   = {1'b0, lfsr_r[6:4]};
                in_range_s = 1'b1;
                occupied_s = array_easy_r[cand_x_s[2:0]][cand_y_s[2:0]];
            end
            2'd2: begin
                cand_x_s   = lfsr_r[3:0];
                cand_y_s   = lfsr_r[7:4];
                in_range_s = (cand_x_s < 4'd10) && (cand_y_s < 4'd10);
                if (in_range_s) begin
                    occupied_s = array_medium_r[cand_x_s][cand_y_s];
                end else begin
                    occupied_s = 1'b0;
                end
            end
            2'd3: begin
                cand_x_s   = lfsr_r[3:0];
                cand_y_s   = lfsr_r[7:4];
                in_range_s = 1'b1;
                occupied_s = array_hard_r[cand_x_s][cand_y_s];
            end
            default: begin
                in_range_s = 1'b0;
                occupied_s = 1'b0;
            end
        endcase
    end

    assign cx6_s = {2'b00, cand_x_s};
    assign cy6_s = {2'b00, cand_y_s};
    assign sx6_s = {1'b0, safe_cx_r};
    assign sy6_s = {1'b0, safe_cy_r};

    // Keep-out test; board-edge clipping falls out of the unsigned comparisons.
    always_comb begin
        excluded_s = 1'b0;
        if (safe_valid_r) begin
`ifdef MINE_PLACER_SAFE_NEIGHBOURS_EN
            excluded_s = (cx6_s + 6'd1 >= sx6_s) && (cx6_s <= sx6_s + 6'd1) &&
                         (cy6_s + 6'd1 >= sy6_s) && (cy6_s <= sy6_s + 6'd1);
`else
            excluded_s = (cx6_s == sx6_s) && (cy6_s == sy6_s);
`endif
        end else begin
            excluded_s = 1'b0;
        end
    end

    assign accept_s = (state_r == ST_PLACE) && in_range_s && !occupied_s && !excluded_s;

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: state_nxt_s = ST_PLACE;
            ST_PLACE: begin
                if (accept_s && (placed_inc_s == target_r)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_PLACE;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_CLEAR: busy_nxt_s = 1'b1;
            ST_PLACE: busy_nxt_s = 1'b1;
            ST_DONE:  done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Request latching, board clearing and mine placement.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r        <= 2'd0;
            safe_cx_r      <= 5'd0;
            safe_cy_r      <= 5'd0;
            safe_valid_r   <= 1'b0;
            target_r       <= 6'd0;
            placed_r       <= 6'd0;
            array_easy_r   <= '0;
            array_medium_r <= '0;
            array_hard_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        level_r      <= level;
                        safe_valid_r <= (safe_x != 5'd0) && (safe_y != 5'd0);
                        safe_cx_r    <= safe_x - 5'd1;
                        safe_cy_r    <= safe_y - 5'd1;
                        case (level)
                            2'd1:    target_r <= TGT_EASY;
                            2'd2:    target_r <= TGT_MEDIUM;
                            2'd3:    target_r <= TGT_HARD;
                            default: target_r <= 6'd0;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    placed_r       <= 6'd0;
                    array_easy_r   <= '0;
                    array_medium_r <= '0;
                    array_hard_r   <= '0;
                end
                ST_PLACE: begin
                    if (accept_s) begin
                        placed_r <= placed_inc_s;
                        case (level_r)
                            2'd1:    array_easy_r[cand_x_s[2:0]][cand_y_s[2:0]] <= 1'b1;
                            2'd2:    array_medium_r[cand_x_s][cand_y_s]         <= 1'b1;
                            2'd3:    array_hard_r[cand_x_s][cand_y_s]           <= 1'b1;
                            default: placed_r <= placed_r;
                        endcase
                    end
                end
                default: placed_r <= placed_r;
            endcase
        end
    end

    assign array_easy_out   = array_easy_r;
    assign array_medium_out = array_medium_r;
    assign array_hard_out   = array_hard_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign mines_placed     = placed_r;

endmodule
